// File: rtl/input_command_scheduler.sv
// Input command scheduler: turns debounced button levels into one-deep
// pending commands and offers them over a valid/ready port. Left and right
// also auto-repeat (DAS delay, then ARR period) while held alone.
module input_command_scheduler #(
  parameter int unsigned DAS_CYCLES = 20_000_000,
  parameter int unsigned ARR_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       btn_drop,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  input  logic       cmd_ready,
  output logic       overrun,
  output logic [1:0] dbg_hstate
);

  // Handshake: a command transfers at a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_code holds while cmd_valid=1 and
  // cmd_ready=0 unless a higher-priority command becomes pending.

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_DELAY  = 2'd1,
    H_REPEAT = 2'd2
  } h_state_e;

  localparam logic [31:0] DAS_LAST = 32'(DAS_CYCLES - 1);
  localparam logic [31:0] ARR_LAST = 32'(ARR_CYCLES - 1);

  // Bit order for buttons and pending: [3] drop, [2] rotate, [1] right, [0] left.
  logic [3:0] btn_now;
  logic [3:0] btn_old_q, btn_old_d;
  logic [3:0] pend_q, pend_d;
  logic       overrun_q, overrun_d;
  h_state_e   h_state_q, h_state_d;
  logic [31:0] hcnt_q, hcnt_d;
  logic       hdir_q, hdir_d;  // 0 = left, 1 = right

  logic [3:0] press_ev;
  logic [3:0] rep_ev;
  logic [3:0] events;
  logic [3:0] sel;
  logic [3:0] clear;
  logic [2:0] code;
  logic       rep_fire;
  logic       hdir_held;
  logic       both_held;
  logic       xfer;

  assign btn_now   = {btn_drop, btn_rotate, btn_right, btn_left};
  assign btn_old_d = btn_now;
  assign press_ev  = btn_now & ~btn_old_q;
  assign hdir_held = hdir_q ? btn_right : btn_left;
  assign both_held = btn_left & btn_right;

  // Horizontal auto-repeat FSM: next state, counter and repeat strobe.
  always_comb begin
    h_state_d = h_state_q;
    hcnt_d    = hcnt_q;
    hdir_d    = hdir_q;
    rep_fire  = 1'b0;
    if (!enable) begin
      h_state_d = H_IDLE;
      hcnt_d    = '0;
    end else begin
      case (h_state_q)
        H_IDLE: begin
          if (btn_left ^ btn_right) begin
            h_state_d = H_DELAY;
            hcnt_d    = '0;
            hdir_d    = btn_right;
          end
        end
        H_DELAY: begin
          if (!hdir_held || both_held) begin
            h_state_d = H_IDLE;
            hcnt_d    = '0;
          end else if (hcnt_q == DAS_LAST) begin
            rep_fire  = 1'b1;
            hcnt_d    = '0;
            h_state_d = H_REPEAT;
          end else begin
            hcnt_d = hcnt_q + 32'd1;
          end
        end
        H_REPEAT: begin
          if (!hdir_held || both_held) begin
            h_state_d = H_IDLE;
            hcnt_d    = '0;
          end else if (hcnt_q == ARR_LAST) begin
            rep_fire = 1'b1;
            hcnt_d   = '0;
          end else begin
            hcnt_d = hcnt_q + 32'd1;
          end
        end
        default: begin
          h_state_d = H_IDLE;
          hcnt_d    = '0;
        end
      endcase
    end
  end

  assign rep_ev = rep_fire ? (hdir_q ? 4'b0010 : 4'b0001) : 4'b0000;
  assign events = enable ? (press_ev | rep_ev) : 4'b0000;

  // Fixed priority select over pending bits: drop > rotate > left > right.
  always_comb begin
    sel  = 4'b0000;
    code = 3'd0;
    if (pend_q[3]) begin
      sel  = 4'b1000;
      code = 3'd4;
    end else if (pend_q[2]) begin
      sel  = 4'b0100;
      code = 3'd3;
    end else if (pend_q[0]) begin
      sel  = 4'b0001;
      code = 3'd1;
    end else if (pend_q[1]) begin
      sel  = 4'b0010;
      code = 3'd2;
    end
  end

  // Outputs are masked by enable so nothing is offered or flagged while paused.
  assign cmd_valid  = enable & (|pend_q);
  assign cmd_code   = cmd_valid ? code : 3'd0;
  assign overrun    = enable & overrun_q;
  assign dbg_hstate = h_state_q;

  assign xfer  = cmd_valid & cmd_ready;
  assign clear = xfer ? sel : 4'b0000;

  // Pending update: a transferring bit hit by a new event stays set without
  // overrun; an event on a set, non-transferring bit is an overrun.
  always_comb begin
    pend_d    = 4'b0000;
    overrun_d = 1'b0;
    if (enable) begin
      pend_d    = (pend_q & ~clear) | events;
      overrun_d = |(events & pend_q & ~clear);
    end
  end

  // State registers; btn_old loads the live buttons during reset so a
  // button held across reset release is not seen as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_old_q <= btn_now;
      pend_q    <= 4'b0000;
      overrun_q <= 1'b0;
      h_state_q <= H_IDLE;
      hcnt_q    <= '0;
      hdir_q    <= 1'b0;
    end else begin
      btn_old_q <= btn_old_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      h_state_q <= h_state_d;
      hcnt_q    <= hcnt_d;
      hdir_q    <= hdir_d;
    end
  end

endmodule

// File: tb/tb_input_command_scheduler.sv
// Bench for input_command_scheduler with short DAS/ARR timing.
module tb_input_command_scheduler;

  localparam int DAS = 8;
  localparam int ARR = 4;
  localparam int W   = 35;  // {code[2:0], expected transfer edge[31:0]}

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       btn_left, btn_right, btn_rotate, btn_drop;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;
  logic       overrun;
  logic [1:0] dbg_hstate;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;  // rising edges seen so far
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [3:0] btn;   // {drop, rotate, right, left}
    logic       rdy;
    logic       en;
    logic [2:0] xfer;  // code transferred at this record's edge, 0 = none
    logic       exp_valid;
    logic [2:0] exp_code;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[28];

  input_command_scheduler #(.DAS_CYCLES(DAS), .ARR_CYCLES(ARR)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_rotate (btn_rotate),
    .btn_drop   (btn_drop),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready),
    .overrun    (overrun),
    .dbg_hstate (dbg_hstate)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [2:0] code, input int edge_n);
    exp_q.push_back({code, 32'(edge_n)});
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_drop, btn_rotate, btn_right, btn_left} = b;
  endtask

  // One clock: scoreboard check at the falling edge, then advance past the
  // next rising edge. Inputs change only #1 after a rising edge.
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    if (!reset && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_xfer: got code %0d at edge %0d, expected none", cmd_code, cyc + 1);
      end else begin
        e = exp_q.pop_front();
        check("xfer_code", 32'(cmd_code), 32'(e[34:32]));
        check("xfer_edge", 32'(cyc + 1), e[31:0]);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic gap();
    set_btn(4'b0000);
    cmd_ready = 1'b1;
    repeat ($urandom_range(2, 5)) tick();
  endtask

  initial begin
    int p;
    int m;
    //                btn      rdy   en    xfer  v     code  ovr
    vecs[0]  = '{4'b0000, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{4'b0100, 1'b1, 1'b1, 3'd0, 1'b1, 3'd3, 1'b0};
    vecs[2]  = '{4'b0100, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0};
    vecs[3]  = '{4'b0000, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0};
    vecs[4]  = '{4'b1010, 1'b0, 1'b1, 3'd0, 1'b1, 3'd4, 1'b0};
    vecs[5]  = '{4'b1010, 1'b0, 1'b1, 3'd0, 1'b1, 3'd4, 1'b0};
    vecs[6]  = '{4'b0000, 1'b0, 1'b1, 3'd0, 1'b1, 3'd4, 1'b0};
    vecs[7]  = '{4'b0000, 1'b1, 1'b1, 3'd4, 1'b1, 3'd2, 1'b0};
    vecs[8]  = '{4'b0000, 1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0};
    vecs[9]  = '{4'b0100, 1'b0, 1'b1, 3'd0, 1'b1, 3'd3, 1'b0};
    vecs[10] = '{4'b0000, 1'b0, 1'b1, 3'd0, 1'b1, 3'd3, 1'b0};
    vecs[11] = '{4'b0100, 1'b0, 1'b1, 3'd0, 1'b1, 3'd3, 1'b1};
    vecs[12] = '{4'b0000, 1'b0, 1'b1, 3'd0, 1'b1, 3'd3, 1'b0};
    vecs[13] = '{4'b0000, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0};
    vecs[14] = '{4'b0000, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0};
    vecs[15] = '{4'b0001, 1'b0, 1'b1, 3'd0, 1'b1, 3'd1, 1'b0};
    vecs[16] = '{4'b1000, 1'b0, 1'b1, 3'd0, 1'b1, 3'd4, 1'b0};
    vecs[17] = '{4'b0000, 1'b1, 1'b1, 3'd4, 1'b1, 3'd1, 1'b0};
    vecs[18] = '{4'b0000, 1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0};
    vecs[19] = '{4'b0100, 1'b0, 1'b1, 3'd0, 1'b1, 3'd3, 1'b0};
    vecs[20] = '{4'b0000, 1'b0, 1'b1, 3'd0, 1'b1, 3'd3, 1'b0};
    vecs[21] = '{4'b0100, 1'b1, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0};
    vecs[22] = '{4'b0000, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0};
    vecs[23] = '{4'b0100, 1'b0, 1'b1, 3'd0, 1'b1, 3'd3, 1'b0};
    vecs[24] = '{4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
    vecs[25] = '{4'b0100, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
    vecs[26] = '{4'b0100, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0};
    vecs[27] = '{4'b0000, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0};

    // Reset
    reset     = 1'b1;
    enable    = 1'b1;
    cmd_ready = 1'b0;
    set_btn(4'b0000);
    tick();
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_code", 32'(cmd_code), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_hstate", 32'(dbg_hstate), 32'd0);
    tick();
    reset     = 1'b0;
    cmd_ready = 1'b1;
    tick();

    // Table: single presses, priority, hold, overrun, same-edge re-press, enable
    for (int i = 0; i < 28; i++) begin
      set_btn(vecs[i].btn);
      cmd_ready = vecs[i].rdy;
      enable    = vecs[i].en;
      if (vecs[i].xfer != 3'd0) push(vecs[i].xfer, cyc + 1);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(cmd_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_code", i), 32'(cmd_code), 32'(vecs[i].exp_code));
      check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].exp_ovr));
    end
    gap();

    // Left held 20 cycles: press, then DAS repeat, then ARR repeats
    set_btn(4'b0001);
    p = cyc + 1;
    push(3'd1, p + 1);
    push(3'd1, p + 1 + DAS);
    push(3'd1, p + 1 + DAS + ARR);
    push(3'd1, p + 1 + DAS + 2 * ARR);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == DAS) check("hold_hstate_repeat", 32'(dbg_hstate), 32'd2);
    end
    set_btn(4'b0000);
    repeat (6) tick();
    check("hold_release_valid", 32'(cmd_valid), 32'd0);
    gap();

    // Left held, right pressed: no repeats while both held, DAS restarts on release
    set_btn(4'b0001);
    p = cyc + 1;
    push(3'd1, p + 1);
    repeat (3) tick();
    set_btn(4'b0011);
    push(3'd2, p + 4);
    repeat (10) tick();
    check("both_hstate_idle", 32'(dbg_hstate), 32'd0);
    set_btn(4'b0001);
    m = cyc + 1;
    push(3'd1, m + DAS + 1);
    tick();
    check("reenter_hstate_delay", 32'(dbg_hstate), 32'd1);
    repeat (9) tick();
    set_btn(4'b0000);
    repeat (6) tick();
    gap();

    // Reset mid-handshake with left held: offer discarded, no press on release
    cmd_ready = 1'b0;
    set_btn(4'b0001);
    p = cyc + 1;
    tick();
    tick();
    check("pre_rst_valid", 32'(cmd_valid), 32'd1);
    check("pre_rst_code", 32'(cmd_code), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(cmd_valid), 32'd0);
    reset     = 1'b0;
    cmd_ready = 1'b1;
    push(3'd1, p + 3 + DAS + 1);
    repeat (11) tick();
    set_btn(4'b0000);
    repeat (6) tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_command_scheduler.md
INPUT_COMMAND_SCHEDULER -- requirements
Module: input_command_scheduler

Interface
REQ-001 Parameter DAS_CYCLES, default 20_000_000, is the number of hold cycles before the first horizontal auto-repeat (200 ms at 100 MHz).
REQ-002 Parameter ARR_CYCLES, default 5_000_000, is the number of cycles between horizontal auto-repeats.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  is the synchronous, active-high reset.
REQ-005 enable  input  1  lets game logic accept commands; low during game over or pause.
REQ-006 btn_left, btn_right, btn_rotate, btn_drop  input  1 each  are debounced button levels; 1 means pressed.
REQ-007 cmd_valid  output  1  means a command is offered.
REQ-008 cmd_code  output  3  carries the command: 1 left, 2 right, 3 rotate, 4 drop, 0 when cmd_valid is low.
REQ-009 cmd_ready  input  1  means game logic accepts the command; a transfer occurs when cmd_valid and cmd_ready are both high at a rising edge.
REQ-010 overrun  output  1  is a one-cycle pulse when an event hits an already-pending command.

Function
REQ-011 The block SHALL register the previous sample of each button (btn_old); a press event occurs at an edge where btn=1 and btn_old=0.
REQ-012 The block SHALL keep a 4-bit pending register, one bit per command; an event SHALL set its bit at that same edge.
REQ-013 cmd_valid SHALL be the OR of the pending bits, driven directly from registers; a press is therefore offered in the cycle after the edge that detects it.
REQ-014 cmd_code SHALL follow fixed priority over the pending bits: drop > rotate > left > right.
REQ-015 cmd_code SHALL remain stable while cmd_valid=1 and cmd_ready=0, unless a higher-priority bit becomes pending.
REQ-016 On a transfer, the bit selected by cmd_code SHALL clear.
REQ-017 If the same bit gets a new event and a transfer at the same edge, the bit SHALL stay set and overrun SHALL stay low.
REQ-018 If an event targets a bit already set and that bit is not transferring, the bit SHALL stay set and overrun SHALL be 1 for the next cycle; events SHALL NOT be queued beyond one per command.
REQ-019 Rotate and drop SHALL generate only press events, with no auto-repeat.
REQ-020 The horizontal FSM SHALL have three states: H_IDLE, H_DELAY and H_REPEAT, with a 32-bit counter hcnt and a direction register hdir.
REQ-021 H_IDLE -> H_DELAY, with hcnt=0 and hdir set to the held button, when exactly one of left or right is held.
REQ-022 In H_DELAY, hcnt SHALL increment each cycle; when hcnt=DAS_CYCLES-1, the FSM SHALL issue a repeat event for hdir, clear hcnt and go to H_REPEAT.
REQ-023 In H_REPEAT, when hcnt=ARR_CYCLES-1, the FSM SHALL issue a repeat event for hdir and clear hcnt; otherwise hcnt SHALL increment.
REQ-024 In H_DELAY or H_REPEAT, if the hdir button is released or both left and right are held, the FSM SHALL go to H_IDLE with hcnt=0 at that edge and issue no repeat event.
REQ-025 If both directions are held and one is then released, the remaining held direction SHALL re-enter H_DELAY with no press event, since its btn_old=1.
REQ-026 A repeat event SHALL set the pending bit exactly as a press does, including the overrun rules.
REQ-027 While enable=0, the pending bits SHALL clear, events SHALL be ignored, the FSM SHALL be forced to H_IDLE, cmd_valid SHALL be 0 and overrun SHALL be 0; btn_old SHALL keep tracking the inputs.

Reset
REQ-028 While reset=1, pending, overrun, hcnt and hdir SHALL be 0 and the FSM SHALL be in H_IDLE, so cmd_valid=0 and cmd_code=0 in the following cycle.
REQ-029 During reset, btn_old SHALL load the current button levels, so a button held through reset release generates no press event.
REQ-030 Reset asserted mid-handshake SHALL discard the offered command; reset SHALL take precedence over enable and all events.

Verification (DAS_CYCLES=8, ARR_CYCLES=4)
REQ-031 Rotate rises at edge N with cmd_ready=1 -> cmd_valid=1 and cmd_code=3 for exactly one cycle after edge N; pending is clear after edge N+1.
REQ-032 Left held for 20 cycles with cmd_ready=1 -> left commands are transferred at press plus 1, press plus 9, press plus 13 and press plus 17 (within 1 cycle); no command follows release.
REQ-033 Drop and right rise at the same edge with cmd_ready=0 for 3 cycles -> cmd_code=4 is held stable; after ready goes high, the order is 4 then 2.
REQ-034 Rotate pressed, released and pressed again while cmd_ready=0 -> overrun pulses once; only one rotate is transferred.
REQ-035 Left held, right then pressed -> right press is transferred and no repeats occur while both are held; after right is released, a left repeat occurs 8 cycles later.
REQ-036 Reset pulsed while cmd_valid=1 and left is held -> cmd_valid=0 after reset and no left command is issued until DAS expires.
